// File: rtl/regfile_pkg.sv
// ============================================================================
// Module  : regfile_pkg
// Brief   : Shared types and default constants for the multiport register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;
  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  localparam int          RF_XLEN    = 32;
  localparam int          RF_NREGS   = 32;
  localparam logic [31:0] RF_SP_INIT = 32'h0000_03FC;
endpackage

`default_nettype wire

// File: rtl/regfile_read_port.sv
// ============================================================================
// Module  : regfile_read_port
// Brief   : One asynchronous read port: address mux, x0 forcing, ready gating
//           and optional write-to-read forwarding (enabled by BYPASS).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_read_port #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b0
) (
  input  logic [XLEN-1:0] mem [NREGS],
  input  logic [AW-1:0]   addr,
  input  logic            ready,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] data
);

  logic w_hit;

  // addr is known non-zero where this is used, so wr_addr is non-zero too
  assign w_hit = wr_en && !rst && (addr == wr_addr);

  always_comb begin
    data = '0;
    if (ready && (addr != '0)) begin
      data = mem[addr];
      if (BYPASS && w_hit) begin
        data = wr_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_multiport.sv
// ============================================================================
// Module  : regfile_multiport
// Brief   : Parametrised multi-read, single-write register file with a hardware
//           clear sequencer. Define REGFILE_BYPASS_EN for write-to-read forwarding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_multiport
  import regfile_pkg::*;
#(
  parameter  int          XLEN    = RF_XLEN,
  parameter  int          NREGS   = RF_NREGS,
  parameter  int          NREAD   = 2,
  parameter  logic [31:0] SP_INIT = RF_SP_INIT,
  localparam int          AW      = $clog2(NREGS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  output logic                  ready,
  input  logic [AW-1:0]         dbg_addr,
  output logic [XLEN-1:0]       dbg_data
);

`ifdef REGFILE_BYPASS_EN
  localparam bit c_bypass = 1'b1;
`else
  localparam bit c_bypass = 1'b0;
`endif

  localparam logic [AW:0]     c_last   = (AW+1)'(NREGS - 1);
  localparam logic [AW:0]     c_sp_reg = (AW+1)'(2);
  localparam logic [XLEN-1:0] c_sp_val = XLEN'(SP_INIT);

  rf_state_t       r_state;
  rf_state_t       w_state_nxt;
  logic [AW:0]     r_cnt;
  logic [AW:0]     w_cnt_nxt;
  logic [XLEN-1:0] r_mem [NREGS];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= RF_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == RF_CLEAR) begin
      w_cnt_nxt = r_cnt + 1'b1;
      if (r_cnt == c_last) begin
        w_state_nxt = RF_RUN;
      end
    end
  end

  // Storage is left untouched in a reset cycle; the sequencer reloads it afterwards
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (r_state == RF_CLEAR) begin
        r_mem[r_cnt[AW-1:0]] <= (r_cnt == c_sp_reg) ? c_sp_val : '0;
      end else if (wr_en && (wr_addr != '0)) begin
        r_mem[wr_addr] <= wr_data;
      end
    end
  end

  assign ready = (r_state == RF_RUN);

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    regfile_read_port #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .AW     (AW),
      .BYPASS (c_bypass)
    ) u_rd (
      .mem     (r_mem),
      .addr    (rd_addr[k*AW +: AW]),
      .ready   (ready),
      .rst     (RST),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .data    (rd_data[k*XLEN +: XLEN])
    );
  end

  regfile_read_port #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .AW     (AW),
    .BYPASS (1'b0)
  ) u_dbg (
    .mem     (r_mem),
    .addr    (dbg_addr),
    .ready   (ready),
    .rst     (RST),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .data    (dbg_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile_multiport.sv
// ============================================================================
// Module  : tb_regfile_multiport
// Brief   : Self-checking bench: default instance plus a 64-bit/16-reg/3-port one.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_multiport;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] SP = 32'h0000_03FC;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        ready;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  logic [11:0]  rd_addr1 = '0;
  logic [191:0] rd_data1;
  logic         wr_en1 = 1'b0;
  logic [3:0]   wr_addr1 = '0;
  logic [63:0]  wr_data1 = '0;
  logic         ready1;
  logic [3:0]   dbg_addr1 = '0;
  logic [63:0]  dbg_data1;

  int checks = 0;
  int failures = 0;

  logic [31:0] model [32];

  always #5 CLK = ~CLK;

  regfile_multiport dut (
    .CLK(CLK), .RST(RST), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  regfile_multiport #(.XLEN(64), .NREGS(16), .NREAD(3)) dut1 (
    .CLK(CLK), .RST(RST), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .ready(ready1),
    .dbg_addr(dbg_addr1), .dbg_data(dbg_data1)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[2] = SP;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) tick();
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    rd_addr = {5'd5, 5'd2};
    dbg_addr = 5'd2;
    #1;
    checks++;
    if (rd_data !== 64'h0) begin failures++; $display("FAIL reset_rd got=%h exp=0", rd_data); end
    checks++;
    if (dbg_data !== 32'h0) begin failures++; $display("FAIL reset_dbg got=%h exp=0", dbg_data); end
    RST = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      checks++;
      if (ready !== (i >= 32)) begin
        failures++; $display("FAIL clear_ready edge=%0d got=%b exp=%b", i, ready, (i >= 32));
      end
      checks++;
      if (ready1 !== (i >= 16)) begin
        failures++; $display("FAIL clear_ready1 edge=%0d got=%b exp=%b", i, ready1, (i >= 16));
      end
    end
    model_clear();
    rd_addr = {5'd1, 5'd2};
    #1;
    checks++;
    if (rd_data[31:0] !== SP) begin failures++; $display("FAIL sp_init got=%h exp=%h", rd_data[31:0], SP); end
    checks++;
    if (rd_data[63:32] !== 32'h0) begin failures++; $display("FAIL x1_zero got=%h exp=0", rd_data[63:32]); end
    rd_addr = {5'd5, 5'd5};
    #1;
    checks++;
    if (rd_data !== 64'h0) begin failures++; $display("FAIL x5_zero got=%h exp=0", rd_data); end
  endtask

  task automatic test_write_read;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
    tick();
    model[7] = 32'hDEAD_BEEF;
    wr_en = 1'b0;
    rd_addr = {5'd7, 5'd7};
    dbg_addr = 5'd7;
    #1;
    checks++;
    if (rd_data !== {2{32'hDEAD_BEEF}}) begin failures++; $display("FAIL wr_x7 got=%h exp=%h", rd_data, {2{32'hDEAD_BEEF}}); end
    checks++;
    if (dbg_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL dbg_x7 got=%h exp=deadbeef", dbg_data); end
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    tick();
    wr_en = 1'b0;
    rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rd_data !== 64'h0) begin failures++; $display("FAIL wr_x0 got=%h exp=0", rd_data); end
  endtask

  task automatic test_disabled_write;
    wr_en = 1'b0; wr_addr = 5'd7; wr_data = 32'd5;
    rd_addr = {5'd0, 5'd7};
    tick();
    checks++;
    if (rd_data[31:0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_disabled got=%h exp=deadbeef", rd_data[31:0]); end
  endtask

  task automatic test_hazard;
    logic [31:0] exp_pre;
    exp_pre = BYP ? 32'hA5A5 : model[9];
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5;
    rd_addr = {5'd0, 5'd9};
    dbg_addr = 5'd9;
    #1;
    checks++;
    if (rd_data[31:0] !== exp_pre) begin failures++; $display("FAIL hazard_pre got=%h exp=%h", rd_data[31:0], exp_pre); end
    checks++;
    if (dbg_data !== model[9]) begin failures++; $display("FAIL hazard_dbg got=%h exp=%h", dbg_data, model[9]); end
    tick();
    model[9] = 32'hA5A5;
    wr_en = 1'b0;
    checks++;
    if (rd_data[31:0] !== 32'hA5A5) begin failures++; $display("FAIL hazard_post got=%h exp=a5a5", rd_data[31:0]); end
  endtask

  task automatic test_random;
    logic [4:0]  a0, a1, wa, da;
    logic [31:0] wd, e0, e1, ed;
    logic        we;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      a0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a1 = 5'($urandom_range(0, 31));
      da = 5'($urandom_range(0, 31));
      wr_en = we; wr_addr = wa; wr_data = wd;
      rd_addr = {a1, a0}; dbg_addr = da;
      #1;
      e0 = (a0 == 0) ? 32'h0 : (BYP && we && wa != 0 && a0 == wa) ? wd : model[a0];
      e1 = (a1 == 0) ? 32'h0 : (BYP && we && wa != 0 && a1 == wa) ? wd : model[a1];
      ed = (da == 0) ? 32'h0 : model[da];
      checks++;
      if (rd_data !== {e1, e0}) begin
        failures++; $display("FAIL rand_rd n=%0d got=%h exp=%h", n, rd_data, {e1, e0});
      end
      checks++;
      if (dbg_data !== ed) begin
        failures++; $display("FAIL rand_dbg n=%0d got=%h exp=%h", n, dbg_data, ed);
      end
      tick();
      if (we && wa != 0) model[wa] = wd;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset_midrun;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd7;
    tick();
    wr_en = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    rd_addr = {5'd0, 5'd3};
    #1;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL midrun_ready_drop got=%b exp=0", ready); end
    checks++;
    if (rd_data[31:0] !== 32'h0) begin failures++; $display("FAIL midrun_x3_gated got=%h exp=0", rd_data[31:0]); end
    for (int i = 1; i <= 32; i++) begin
      if (i == 5) begin wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'd9; end
      tick();
      wr_en = 1'b0;
      if (i == 31) begin
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL midrun_ready31 got=%b exp=0", ready); end
      end
    end
    model_clear();
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL midrun_ready32 got=%b exp=1", ready); end
    rd_addr = {5'd2, 5'd3};
    #1;
    checks++;
    if (rd_data !== {SP, 32'h0}) begin failures++; $display("FAIL midrun_x3_x2 got=%h exp=%h", rd_data, {SP, 32'h0}); end
    rd_addr = {5'd4, 5'd4};
    #1;
    checks++;
    if (rd_data !== 64'h0) begin failures++; $display("FAIL midrun_x4_lost got=%h exp=0", rd_data); end
  endtask

  task automatic test_sweep;
    logic [63:0] v;
    v = {$urandom, $urandom};
    checks++;
    if (ready1 !== 1'b1) begin failures++; $display("FAIL sweep_ready got=%b exp=1", ready1); end
    wr_en1 = 1'b1; wr_addr1 = 4'd15; wr_data1 = v;
    tick();
    wr_en1 = 1'b0;
    rd_addr1 = {4'd15, 4'd15, 4'd15};
    dbg_addr1 = 4'd2;
    #1;
    checks++;
    if (rd_data1 !== {3{v}}) begin failures++; $display("FAIL sweep_x15 got=%h exp=%h", rd_data1, {3{v}}); end
    checks++;
    if (dbg_data1 !== {32'h0, SP}) begin failures++; $display("FAIL sweep_sp got=%h exp=%h", dbg_data1, {32'h0, SP}); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_disabled_write();
    test_hazard();
    test_random();
    test_reset_midrun();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
